key_lookup_sched: RTL and testbench
===================================

Name: key_lookup_sched

Overview:
Shares one programmable key-match lookup table between NR_REQ requesters. Each requester uses a valid/ready handshake, and the block grants one requester per cycle in round-robin order. A single-entry response buffer returns a registered result, and a configuration port writes table entries. It sits in the NPC alongside decode/CSR logic, for example for opcode→control lookups shared by multiple issue sources.

Parameters:
NR_REQ, 2, number of requesters (≥2)
NR_KEY, 4, number of table entries
KEY_LEN, 8, key width
DATA_LEN, 8, data width
HAS_DEFAULT, 1, 1: miss returns default register; 0: miss returns 0
ID_LEN, 1, requester-id width, ≥ clog2(NR_REQ)
IDX_LEN, 2, entry-index width, ≥ clog2(NR_KEY)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NR_REQ  per-requester request valid
req_key  in  NR_REQ*KEY_LEN  requester i key at [KEY_LEN*(i+1)-1:KEY_LEN*i]
req_ready  out  NR_REQ  one-hot (or zero) grant; handshake i = req_valid[i]&req_ready[i]
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_id  out  ID_LEN  index of requester being answered
resp_data  out  DATA_LEN  lookup result
resp_hit  out  1  at least one valid entry matched
cfg_we  in  1  write entry cfg_idx: vld=1, key=cfg_key, data=cfg_data
cfg_idx  in  IDX_LEN  entry index; values ≥ NR_KEY are ignored
cfg_key  in  KEY_LEN  entry key
cfg_data  in  DATA_LEN  entry data
cfg_clr  in  1  invalidate all entries
cfg_dflt_we  in  1  write default register
cfg_dflt  in  DATA_LEN  default value

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset effects: all entry vld/key/data=0; default=0; resp_valid=0, resp_id=0, resp_data=0, resp_hit=0; RR pointer=NR_REQ-1 so requester 0 has first priority.
- States:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- Grant condition: accept = (EMPTY | resp_ready) & !cfg_we & !cfg_clr & |req_valid.
  - Config ops have priority and block grants in their cycle.
- Grant selection: req_ready asserted only to the RR winner, the first valid requester strictly after the pointer, wrapping modulo NR_REQ.
  - req_ready is all-zero when accept=0.
- Pointer update: the pointer updates to the winner only on a handshake.
- Lookup timing: the lookup uses table contents before any edge-coincident update. Latency is 1 cycle: resp_* are registered at the handshake edge, and FULL is entered or kept.
- Lookup result:
  - match[k] = vld[k] & (key==key[k]).
  - data = OR over k of (match[k] ? data[k] : 0), so duplicate matches OR together.
  - hit = |match.
  - On a miss, resp_data = default if HAS_DEFAULT, else 0.
- FULL & !resp_ready: resp_* held stable and no grant.
- FULL & resp_ready: if a new handshake occurs in the same cycle, stay FULL with new contents (back-to-back, 1 response/cycle); otherwise go to EMPTY.
- Config write timing: writes are visible to lookups granted from the next cycle onward.
- cfg_clr with cfg_we in the same cycle: clear all entries, then the cfg_we entry is written (valid).
- Requester obligations: requesters hold req_valid and req_key stable until handshake. The block does not check this.
- rst asserted mid-response: the pending response is discarded and all state returns to reset values on the next edge.

Decomposition:
- Shared package holds:
  - the state enum (EMPTY/FULL);
  - a table-entry struct {vld, key, data};
  - a clog2 helper for ID/IDX width checks.
- One natural sub-module: rr_arbiter (parameter N; inputs valid, pointer, enable; output one-hot grant, winner index). It is combinational and reused elsewhere. Lookup and table storage stay in the top module.

Test Plan:
(NR_REQ=2, NR_KEY=4, KEY_LEN=8, DATA_LEN=8, HAS_DEFAULT=1 throughout.)
1. Miss after reset: reset 2 cycles; req0 key 0x12 → req_ready=01 same cycle; next cycle resp_valid=1, id=0, hit=0, data=0x00.
2. Write then hit: cfg_we idx1 key 0x12 data 0xA5; next cycle req1 key 0x12 → resp id=1, hit=1, data=0xA5.
3. Round-robin: both req_valid held high, resp_ready=1 → grants 01,10,01,10; resp_id 0,1,0,1 on consecutive cycles.
4. Backpressure: resp_ready=0 for 3 cycles → resp_* unchanged, req_ready=00. Raising resp_ready grants the next requester in that same cycle.
5. Config priority: cfg_we (idx0, key 0x12, data 0x0F) in the same cycle as a request → req_ready=00 that cycle. Grant next cycle returns hit=1, data=0x0F.
6. Duplicates, clear and reset: entries 0 (0x12→0x0F) and 2 (0x12→0xF0) → data 0xFF, hit=1. Then cfg_dflt 0x3C + cfg_clr → lookup 0x12 gives hit=0, data=0x3C. rst while resp_valid=1 → resp_valid=0 after the edge.

Source files
------------

// File: rtl/key_lookup_sched_pkg.sv
// Shared types and helpers for the key-match lookup scheduler.
package key_lookup_sched_pkg;

  localparam int unsigned ENTRY_KEY_LEN  = 8;
  localparam int unsigned ENTRY_DATA_LEN = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic                      vld;
    logic [ENTRY_KEY_LEN-1:0]  key;
    logic [ENTRY_DATA_LEN-1:0] data;
  } entry_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/key_lookup_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester after ptr.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] winner_c
);

  logic found;

  always_comb begin
    found    = 1'b0;
    winner_c = '0;
    // Scan offsets 1..N from the pointer so the pointer itself is lowest priority.
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && valid[j] && (((32'(ptr) + i) % N) == j)) begin
          found    = 1'b1;
          winner_c = IW'(j);
        end
      end
    end
  end

  always_comb begin
    grant_c = '0;
    for (int unsigned j = 0; j < N; j++) begin
      grant_c[j] = en && found && (winner_c == IW'(j));
    end
  end

endmodule

// File: rtl/key_lookup_sched.sv
// Round-robin shared key-match lookup table with a single-entry response buffer
// and a configuration write port.
module key_lookup_sched
  import key_lookup_sched_pkg::*;
#(
  parameter int unsigned NR_REQ      = 2,
  parameter int unsigned NR_KEY      = 4,
  parameter int unsigned KEY_LEN     = 8,
  parameter int unsigned DATA_LEN    = 8,
  parameter int unsigned HAS_DEFAULT = 1,
  parameter int unsigned ID_LEN      = 1,
  parameter int unsigned IDX_LEN     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_REQ-1:0]         req_valid,
  input  logic [NR_REQ*KEY_LEN-1:0] req_key,
  output logic [NR_REQ-1:0]         req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_LEN-1:0]         resp_id,
  output logic [DATA_LEN-1:0]       resp_data,
  output logic                      resp_hit,
  input  logic                      cfg_we,
  input  logic [IDX_LEN-1:0]        cfg_idx,
  input  logic [KEY_LEN-1:0]        cfg_key,
  input  logic [DATA_LEN-1:0]       cfg_data,
  input  logic                      cfg_clr,
  input  logic                      cfg_dflt_we,
  input  logic [DATA_LEN-1:0]       cfg_dflt
);

  if (ID_LEN < clog2(NR_REQ)) begin : g_bad_id_len
    $error("ID_LEN too narrow for NR_REQ");
  end
  if (IDX_LEN < clog2(NR_KEY)) begin : g_bad_idx_len
    $error("IDX_LEN too narrow for NR_KEY");
  end
  if (KEY_LEN != ENTRY_KEY_LEN || DATA_LEN != ENTRY_DATA_LEN) begin : g_bad_entry
    $error("KEY_LEN/DATA_LEN must match the entry_t field widths");
  end

  state_e              state;
  entry_t              tbl [NR_KEY];
  logic [DATA_LEN-1:0] dflt;
  logic [ID_LEN-1:0]   rr_ptr;
  logic [ID_LEN-1:0]   winner_c;
  logic [NR_REQ-1:0]   grant_c;
  logic                arb_en_c;
  logic                accept_c;
  logic [KEY_LEN-1:0]  key_sel_c;
  logic [DATA_LEN-1:0] match_data_c;
  logic                match_hit_c;
  logic [DATA_LEN-1:0] lookup_data_c;

  // Config ops own the cycle; a full buffer only frees up when the consumer takes it.
  assign arb_en_c   = ((state == EMPTY) || resp_ready) && !cfg_we && !cfg_clr;
  assign accept_c   = arb_en_c && (|req_valid);
  assign req_ready  = grant_c;
  assign resp_valid = (state == FULL);

  rr_arbiter #(
    .N  (NR_REQ),
    .IW (ID_LEN)
  ) u_arb (
    .valid    (req_valid),
    .ptr      (rr_ptr),
    .en       (arb_en_c),
    .grant_c  (grant_c),
    .winner_c (winner_c)
  );

  always_comb begin
    key_sel_c = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (winner_c == ID_LEN'(i)) key_sel_c = req_key[i*KEY_LEN +: KEY_LEN];
    end
  end

  // Duplicate matches OR their data together.
  always_comb begin
    match_data_c = '0;
    match_hit_c  = 1'b0;
    for (int unsigned k = 0; k < NR_KEY; k++) begin
      if (tbl[k].vld && (tbl[k].key == key_sel_c)) begin
        match_data_c = match_data_c | tbl[k].data;
        match_hit_c  = 1'b1;
      end
    end
  end

  assign lookup_data_c = match_hit_c ? match_data_c :
                         ((HAS_DEFAULT != 0) ? dflt : '0);

  // Table storage: clear first, then a same-cycle write lands on top.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NR_KEY; k++) tbl[k] <= '0;
      dflt <= '0;
    end else begin
      for (int unsigned k = 0; k < NR_KEY; k++) begin
        if (cfg_clr) tbl[k].vld <= 1'b0;
        if (cfg_we && (cfg_idx == IDX_LEN'(k))) begin
          tbl[k].vld  <= 1'b1;
          tbl[k].key  <= cfg_key;
          tbl[k].data <= cfg_data;
        end
      end
      if (cfg_dflt_we) dflt <= cfg_dflt;
    end
  end

  // Response buffer FSM and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      resp_id   <= '0;
      resp_data <= '0;
      resp_hit  <= 1'b0;
      rr_ptr    <= ID_LEN'(NR_REQ - 1);
    end else begin
      if (accept_c) begin
        state     <= FULL;
        resp_id   <= winner_c;
        resp_data <= lookup_data_c;
        resp_hit  <= match_hit_c;
        rr_ptr    <= winner_c;
      end else if (resp_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_key_lookup_sched.sv
// Directed table-driven bench for key_lookup_sched (2 requesters, 4 entries).
module tb_key_lookup_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_key;
  logic [1:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [0:0]  resp_id;
  logic [7:0]  resp_data;
  logic        resp_hit;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [7:0]  cfg_key;
  logic [7:0]  cfg_data;
  logic        cfg_clr;
  logic        cfg_dflt_we;
  logic [7:0]  cfg_dflt;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_lookup_sched #(
    .NR_REQ(2), .NR_KEY(4), .KEY_LEN(8), .DATA_LEN(8),
    .HAS_DEFAULT(1), .ID_LEN(1), .IDX_LEN(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_hit(resp_hit),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key), .cfg_data(cfg_data),
    .cfg_clr(cfg_clr), .cfg_dflt_we(cfg_dflt_we), .cfg_dflt(cfg_dflt)
  );

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic [7:0] k0, k1;
    logic       rr;
    logic       we;
    logic [1:0] idx;
    logic [7:0] ck, cd;
    logic       clr, dwe;
    logic [7:0] dv;
    logic [1:0] e_rdy;
    logic       e_rv;
    logic       chk;
    logic       e_id;
    logic [7:0] e_data;
    logic       e_hit;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic rst, logic [1:0] rv, logic [7:0] k0, logic [7:0] k1, logic rr,
    logic we, logic [1:0] idx, logic [7:0] ck, logic [7:0] cd,
    logic clr, logic dwe, logic [7:0] dv,
    logic [1:0] e_rdy, logic e_rv, logic chk, logic e_id, logic [7:0] e_data, logic e_hit);
    vec_t v;
    v.rst = rst; v.rv = rv; v.k0 = k0; v.k1 = k1; v.rr = rr;
    v.we = we; v.idx = idx; v.ck = ck; v.cd = cd;
    v.clr = clr; v.dwe = dwe; v.dv = dv;
    v.e_rdy = e_rdy; v.e_rv = e_rv; v.chk = chk;
    v.e_id = e_id; v.e_data = e_data; v.e_hit = e_hit;
    return v;
  endfunction

  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; req_valid = v.rv; req_key = {v.k1, v.k0}; resp_ready = v.rr;
    cfg_we = v.we; cfg_idx = v.idx; cfg_key = v.ck; cfg_data = v.cd;
    cfg_clr = v.clr; cfg_dflt_we = v.dwe; cfg_dflt = v.dv;
  endtask

  initial begin
    // rst rv k0 k1 rr | we idx ck cd clr dwe dv | rdy rv chk id data hit
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b00, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, 2'b00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b00, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 2'b01, 8'h12, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b01, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 2'b00, 8'h12, 8'h00, 1, 1, 1, 8'h12, 8'hA5, 0, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 2'b10, 8'h00, 8'h12, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b10, 1, 1, 1, 8'hA5, 1));
    vecs.push_back(mk(0, 2'b11, 8'h12, 8'h34, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b01, 1, 1, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 2'b11, 8'h12, 8'h34, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b10, 1, 1, 1, 8'h00, 0));
    vecs.push_back(mk(0, 2'b11, 8'h12, 8'h34, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b01, 1, 1, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 2'b11, 8'h12, 8'h34, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b10, 1, 1, 1, 8'h00, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 2'b11, 8'h12, 8'h34, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b00, 1, 1, 1, 8'h00, 0));
    vecs.push_back(mk(0, 2'b11, 8'h12, 8'h34, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b01, 1, 1, 0, 8'hA5, 1));
    vecs.push_back(mk(0, 2'b01, 8'h12, 8'h00, 1, 1, 0, 8'h12, 8'h0F, 1, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 2'b01, 8'h12, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b01, 1, 1, 0, 8'h0F, 1));
    vecs.push_back(mk(0, 2'b00, 8'h12, 8'h00, 1, 1, 2, 8'h12, 8'hF0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 2'b01, 8'h12, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b01, 1, 1, 0, 8'hFF, 1));
    vecs.push_back(mk(0, 2'b00, 8'h12, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h3C, 2'b00, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 2'b01, 8'h12, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b01, 1, 1, 0, 8'h3C, 0));
    vecs.push_back(mk(0, 2'b00, 8'h12, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b00, 1, 1, 0, 8'h3C, 0));
    vecs.push_back(mk(1, 2'b00, 8'h12, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b00, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 2'b11, 8'h12, 8'h34, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b01, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mk(0, 2'b11, 8'h12, 8'h34, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 2'b10, 1, 1, 1, 8'h00, 0));

    foreach (vecs[s]) begin
      @(negedge clk);
      drive(vecs[s]);
      #1;
      check("req_ready", s, 32'(req_ready), 32'(vecs[s].e_rdy));
      @(posedge clk);
      #1;
      check("resp_valid", s, 32'(resp_valid), 32'(vecs[s].e_rv));
      if (vecs[s].chk) begin
        check("resp_id", s, 32'(resp_id), 32'(vecs[s].e_id));
        check("resp_data", s, 32'(resp_data), 32'(vecs[s].e_data));
        check("resp_hit", s, 32'(resp_hit), 32'(vecs[s].e_hit));
      end
    end

    // Write entry 3, then a stalled response must arrive and stay put.
    @(negedge clk);
    rst = 0; req_valid = 2'b00; resp_ready = 1;
    cfg_we = 1; cfg_idx = 2'd3; cfg_key = 8'h77; cfg_data = 8'h5A; cfg_clr = 0; cfg_dflt_we = 0;
    @(negedge clk);
    cfg_we = 0; req_valid = 2'b10; req_key = {8'h77, 8'h12}; resp_ready = 0;
    #1;
    check("seq_ready", 100, 32'(req_ready), 32'(2'b10));
    begin
      int waited;
      waited = 0;
      while (waited < 5) begin
        @(posedge clk);
        #1;
        waited++;
        if (resp_valid) break;
      end
      check("seq_resp_timeout", 101, 32'(resp_valid), 32'd1);
    end
    check("seq_id", 102, 32'(resp_id), 32'd1);
    check("seq_data", 103, 32'(resp_data), 32'h5A);
    check("seq_hit", 104, 32'(resp_hit), 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("seq_hold_ready", 105 + c, 32'(req_ready), 32'(2'b00));
      @(posedge clk);
      #1;
      check("seq_hold_valid", 105 + c, 32'(resp_valid), 32'd1);
      check("seq_hold_data", 105 + c, 32'(resp_data), 32'h5A);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
